// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2State_t;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

endpackage

// File: rtl/ps2_line_filter.sv
// 2-FF synchronisers for both PS/2 lines plus a glitch filter on the clock line
// that yields a clean level and a one-cycle falling-edge strobe.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic boardClk,
  input  logic reset,
  input  logic ps2Clk,
  input  logic ps2Data,
  output logic clkFilt,
  output logic dataSync,
  output logic fall
);

  localparam int CW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    clkSync;
  logic [1:0]    dataSr;
  logic [CW-1:0] cnt;

  assign dataSync = dataSr[1];

  always_ff @(posedge boardClk or negedge reset) begin
    if (!reset) begin
      clkSync <= '1;
      dataSr  <= '1;
      clkFilt <= 1'b1;
      cnt     <= '0;
      fall    <= 1'b0;
    end else begin
      clkSync <= {clkSync[0], ps2Clk};
      dataSr  <= {dataSr[0], ps2Data};
      fall    <= 1'b0;
      if (clkSync[1] == clkFilt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        // Level and strobe update together, so fall coincides with the new low level.
        clkFilt <= ~clkFilt;
        cnt     <= '0;
        fall    <= clkFilt;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard frame receiver: frame FSM, stall watchdog and E0/F0 prefix folding
// producing one make/break event per key action.
module ps2_scan_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       boardClk,
  input  logic       reset,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic [7:0] scanCode,
  output logic       isBreak,
  output logic       isExtended,
  output logic       codeValid,
  output logic       frameErr
);

  localparam int WW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic fall;
  logic dataBit;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) lineFilter (
    .boardClk(boardClk),
    .reset   (reset),
    .ps2Clk  (ps2Clk),
    .ps2Data (ps2Data),
    .clkFilt (),
    .dataSync(dataBit),
    .fall    (fall)
  );

  ps2State_t     state, stateN;
  logic [2:0]    bitCnt, bitCntN;
  logic [7:0]    shiftReg, shiftRegN;
  logic          parityBit, parityBitN;
  logic [WW-1:0] wdCnt, wdCntN;
  logic          extPend, extPendN;
  logic          brkPend, brkPendN;
  logic [7:0]    scanCodeN;
  logic          isBreakN, isExtendedN, codeValidN, frameErrN;

  always_ff @(posedge boardClk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      bitCnt     <= '0;
      shiftReg   <= '0;
      parityBit  <= 1'b0;
      wdCnt      <= '0;
      extPend    <= 1'b0;
      brkPend    <= 1'b0;
      scanCode   <= '0;
      isBreak    <= 1'b0;
      isExtended <= 1'b0;
      codeValid  <= 1'b0;
      frameErr   <= 1'b0;
    end else begin
      state      <= stateN;
      bitCnt     <= bitCntN;
      shiftReg   <= shiftRegN;
      parityBit  <= parityBitN;
      wdCnt      <= wdCntN;
      extPend    <= extPendN;
      brkPend    <= brkPendN;
      scanCode   <= scanCodeN;
      isBreak    <= isBreakN;
      isExtended <= isExtendedN;
      codeValid  <= codeValidN;
      frameErr   <= frameErrN;
    end
  end

  always_comb begin
    stateN      = state;
    bitCntN     = bitCnt;
    shiftRegN   = shiftReg;
    parityBitN  = parityBit;
    wdCntN      = wdCnt;
    extPendN    = extPend;
    brkPendN    = brkPend;
    scanCodeN   = scanCode;
    isBreakN    = isBreak;
    isExtendedN = isExtended;
    codeValidN  = 1'b0;
    frameErrN   = 1'b0;

    if (fall) begin
      wdCntN = '0;
      unique case (state)
        IDLE: begin
          if (!dataBit) begin
            stateN    = DATA;
            bitCntN   = '0;
            shiftRegN = '0;
          end
        end
        DATA: begin
          shiftRegN = {dataBit, shiftReg[7:1]};
          if (bitCnt == 3'd7) stateN = PARITY;
          else                bitCntN = bitCnt + 1'b1;
        end
        PARITY: begin
          parityBitN = dataBit;
          stateN     = STOP;
        end
        STOP: begin
          stateN = IDLE;
          if (dataBit && ((^shiftReg) ^ parityBit)) begin
            if (shiftReg == PS2_PFX_EXT) begin
              extPendN = 1'b1;
            end else if (shiftReg == PS2_PFX_BRK) begin
              brkPendN = 1'b1;
            end else begin
              scanCodeN   = shiftReg;
              isBreakN    = brkPend;
              isExtendedN = extPend;
              codeValidN  = 1'b1;
              extPendN    = 1'b0;
              brkPendN    = 1'b0;
            end
          end else begin
            frameErrN = 1'b1;
            extPendN  = 1'b0;
            brkPendN  = 1'b0;
          end
        end
        default: stateN = IDLE;
      endcase
    end else if (state != IDLE) begin
      // A fall in the same cycle takes the branch above, so it always beats the timeout.
      if (wdCnt == WW'(TIMEOUT_CYCLES - 1)) begin
        stateN    = IDLE;
        frameErrN = 1'b1;
        extPendN  = 1'b0;
        brkPendN  = 1'b0;
        shiftRegN = '0;
        bitCntN   = '0;
        wdCntN    = '0;
      end else begin
        wdCntN = wdCnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Self-checking bench: frame-level event model with a per-cycle output checker.
module tb_ps2_scan_receiver;

  localparam int FLEN = 8;
  localparam int TOUT = 2000;
  localparam int HALF = 40;

  logic       boardClk = 1'b0;
  logic       reset    = 1'b0;
  logic       ps2Clk   = 1'b1;
  logic       ps2Data  = 1'b1;
  logic [7:0] scanCode;
  logic       isBreak, isExtended, codeValid, frameErr;

  ps2_scan_receiver #(
    .FILTER_LEN    (FLEN),
    .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .boardClk  (boardClk),
    .reset     (reset),
    .ps2Clk    (ps2Clk),
    .ps2Data   (ps2Data),
    .scanCode  (scanCode),
    .isBreak   (isBreak),
    .isExtended(isExtended),
    .codeValid (codeValid),
    .frameErr  (frameErr)
  );

  always #5 boardClk = ~boardClk;

  typedef struct {
    bit         err;
    logic [7:0] code;
    bit         brk;
    bit         ext;
  } ev_t;

  ev_t        expQ[$];
  bit         mExt = 1'b0;
  bit         mBrk = 1'b0;
  logic [7:0] lastCode = 8'h00;
  bit         lastBrk = 1'b0;
  bit         lastExt = 1'b0;
  int         vectors = 0;
  int         miscompares = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: what the downstream stage should see for one frame.
  function automatic void modelFrame(input logic [7:0] b, input bit good);
    ev_t e;
    if (!good) begin
      e = '{1'b1, 8'h00, 1'b0, 1'b0};
      expQ.push_back(e);
      mExt = 1'b0;
      mBrk = 1'b0;
    end else if (b == 8'hE0) begin
      mExt = 1'b1;
    end else if (b == 8'hF0) begin
      mBrk = 1'b1;
    end else begin
      e = '{1'b0, b, mBrk, mExt};
      expQ.push_back(e);
      mExt = 1'b0;
      mBrk = 1'b0;
    end
  endfunction

  always @(negedge boardClk) begin
    ev_t e;
    if (!reset) begin
      chk("rst_scanCode", scanCode, 8'h00);
      chk("rst_flags", {4'b0, isBreak, isExtended, codeValid, frameErr}, 8'h00);
      lastCode = 8'h00;
      lastBrk  = 1'b0;
      lastExt  = 1'b0;
    end else begin
      if (codeValid || frameErr) begin
        if (expQ.size() == 0) begin
          chk("unexpected_pulse", {6'b0, codeValid, frameErr}, 8'h00);
        end else begin
          e = expQ.pop_front();
          chk("pulse_kind", {6'b0, codeValid, frameErr}, e.err ? 8'h01 : 8'h02);
          if (!e.err) begin
            lastCode = e.code;
            lastBrk  = e.brk;
            lastExt  = e.ext;
          end
        end
      end
      chk("scanCode", scanCode, lastCode);
      chk("flags", {6'b0, isBreak, isExtended}, {6'b0, lastBrk, lastExt});
    end
  end

  task automatic waitCyc(input int n);
    repeat (n) @(negedge boardClk);
  endtask

  task automatic sendBit(input bit b, input bit glitch);
    ps2Data = b;
    if (glitch) begin
      waitCyc(10);
      ps2Clk = 1'b0;
      waitCyc(FLEN - 3);
      ps2Clk = 1'b1;
      waitCyc(HALF - 10 - (FLEN - 3));
    end else begin
      waitCyc(HALF);
    end
    ps2Clk = 1'b0;
    waitCyc(HALF);
    ps2Clk = 1'b1;
  endtask

  task automatic sendFrame(input logic [7:0] b, input bit badPar, input bit badStop,
                           input int glitchBit);
    logic [10:0] bits;
    bits = {~badStop, (~^b) ^ badPar, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      if (i == 10) modelFrame(b, !(badPar || badStop));
      sendBit(bits[i], i == glitchBit);
    end
    ps2Data = 1'b1;
    waitCyc(2 * HALF);
  endtask

  task automatic sendPartial(input logic [7:0] b, input int nData);
    sendBit(1'b0, 1'b0);
    for (int i = 0; i < nData; i++) sendBit(b[i], 1'b0);
    ps2Data = 1'b1;
  endtask

  initial begin
    int r;
    logic [7:0] code;
    waitCyc(3);
    chk("reset_valid", {6'b0, codeValid, frameErr}, 8'h00);
    #2 reset = 1'b1;
    waitCyc(20);

    sendFrame(8'h1C, 1'b0, 1'b0, -1);
    chk("make_1C_code", scanCode, 8'h1C);
    chk("make_1C_flags", {6'b0, isBreak, isExtended}, 8'h00);

    sendFrame(8'hF0, 1'b0, 1'b0, -1);
    sendFrame(8'h1C, 1'b0, 1'b0, -1);
    chk("brk_1C_code", scanCode, 8'h1C);
    chk("brk_1C_flags", {6'b0, isBreak, isExtended}, 8'h02);
    sendFrame(8'h1C, 1'b0, 1'b0, -1);
    chk("after_brk_flags", {6'b0, isBreak, isExtended}, 8'h00);

    sendFrame(8'hE0, 1'b0, 1'b0, -1);
    sendFrame(8'hF0, 1'b0, 1'b0, -1);
    sendFrame(8'h75, 1'b0, 1'b0, -1);
    chk("ext_brk_75_code", scanCode, 8'h75);
    chk("ext_brk_75_flags", {6'b0, isBreak, isExtended}, 8'h03);

    sendFrame(8'hF0, 1'b0, 1'b0, -1);
    sendFrame(8'h1C, 1'b1, 1'b0, -1);
    sendFrame(8'h1C, 1'b0, 1'b1, -1);
    sendFrame(8'h32, 1'b0, 1'b0, -1);
    chk("after_err_code", scanCode, 8'h32);
    chk("after_err_flags", {6'b0, isBreak, isExtended}, 8'h00);

    sendFrame(8'hE0, 1'b0, 1'b0, -1);
    sendPartial(8'h29, 4);
    modelFrame(8'h00, 1'b0);
    waitCyc(TOUT + 1000);
    chk("timeout_drained", 8'(expQ.size()), 8'h00);
    sendFrame(8'h29, 1'b0, 1'b0, -1);
    chk("after_tout_code", scanCode, 8'h29);
    chk("after_tout_flags", {6'b0, isBreak, isExtended}, 8'h00);

    sendFrame(8'h5A, 1'b0, 1'b0, 4);
    chk("glitch_code", scanCode, 8'h5A);

    sendFrame(8'hF0, 1'b0, 1'b0, -1);
    sendPartial(8'h44, 5);
    #2 reset = 1'b0;
    #1;
    chk("midreset_code", scanCode, 8'h00);
    chk("midreset_flags", {4'b0, isBreak, isExtended, codeValid, frameErr}, 8'h00);
    mExt = 1'b0;
    mBrk = 1'b0;
    ps2Clk  = 1'b1;
    ps2Data = 1'b1;
    waitCyc(5);
    #2 reset = 1'b1;
    waitCyc(20);
    sendFrame(8'h1C, 1'b0, 1'b0, -1);
    chk("post_reset_code", scanCode, 8'h1C);
    chk("post_reset_flags", {6'b0, isBreak, isExtended}, 8'h00);

    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 7));
      if (r < 2)       code = 8'hE0;
      else if (r < 4)  code = 8'hF0;
      else             code = 8'($urandom_range(0, 255));
      sendFrame(code, $urandom_range(0, 9) == 0, $urandom_range(0, 15) == 0,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1);
    end

    waitCyc(200);
    chk("queue_empty", 8'(expQ.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_scan_receiver.md
# ps2_scan_receiver

Receives PS/2 keyboard frames on the raw `ps2Clk`/`ps2Data` lines, runs in the board clock domain, and presents one decoded make/break scan-code event per key action. It sits directly upstream of the keyboard-code decode stage: its `scanCode`/`codeValid` outputs feed the decoder, which maps codes to display colours for the VGA display controller. Line synchronisation, glitch filtering, frame checking, a stall watchdog and E0/F0 prefix folding are all handled here. The downstream stage sees only complete, validated key events.

## Interface
Parameters:
- `FILTER_LEN`, 8: consecutive equal samples of synchronised `ps2Clk` required to accept a level change.
- `TIMEOUT_CYCLES`, 100000: board-clock cycles without a filtered falling edge before a partial frame is abandoned (2 ms at 50 MHz).

Ports:
- `boardClk`  in  1  board clock; the only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `ps2Clk`  in  1  raw PS/2 clock line (asynchronous).
- `ps2Data`  in  1  raw PS/2 data line (asynchronous).
- `scanCode`  out  8  last accepted non-prefix code byte; held until the next event.
- `isBreak`  out  1  event was preceded by F0 (key release); valid with `codeValid`, then held.
- `isExtended`  out  1  event was preceded by E0; valid with `codeValid`, then held.
- `codeValid`  out  1  single-cycle pulse per emitted event.
- `frameErr`  out  1  single-cycle pulse on parity, stop-bit or timeout error.

## Operation
- Both lines pass through 2-FF synchronisers.
- `ps2Clk` filter:
  - A saturating counter (0..FILTER_LEN-1) counts consecutive samples that differ from the filtered level.
  - The filtered level flips when the count reaches FILTER_LEN-1.
  - The counter clears on any sample equal to the filtered level.
  - The filtered level resets to 1.
- Falling edge is the filtered level going 1→0. It produces a one-cycle `fall` strobe, and the synchronised data bit is sampled on that same cycle.
- FSM states, advanced only on `fall` (except timeout):
  - IDLE: on a sampled data bit of 0 (start bit), go to DATA and clear the bit counter and shift register. A sampled 1 stays in IDLE; no error is flagged.
  - DATA: shift bits in LSB-first into an 8-bit register. After the 8th bit, go to PARITY.
  - PARITY: store the bit, then go to STOP.
  - STOP: check the frame, then return to IDLE.
    - Good frame: stop bit = 1 and the XOR of the 8 data bits and the parity bit = 1 (odd parity).
    - Bad frame: pulse `frameErr`, clear the pending prefix flags, emit nothing.
- Prefix folding on a good frame:
  - 0xE0 sets `extPend`.
  - 0xF0 sets `brkPend`.
  - Any other byte loads `scanCode`, loads `isBreak`/`isExtended` from the pend flags, pulses `codeValid`, and clears both pend flags.
  - A repeated prefix leaves its flag set; prefixes are never emitted.
- Watchdog:
  - Counter runs in DATA/PARITY/STOP and clears on every `fall`.
  - On reaching TIMEOUT_CYCLES-1: return to IDLE, pulse `frameErr`, clear the pend flags, discard the partial byte.
  - If timeout and `fall` occur in the same cycle, `fall` wins.
- Reset (async, any time, including mid-frame):
  - FSM to IDLE; all counters, shift register and pend flags to 0.
  - Filter and synchroniser flops to 1.
  - All outputs to 0.

## Timing
- `codeValid`/`frameErr` assert on the cycle after the STOP-bit `fall` (registered). `scanCode` and the flags are valid on that same cycle.
- Latency from a raw `ps2Clk` falling edge to `fall` is 2 (sync) + FILTER_LEN-1 (filter) + 1 cycles.
- `codeValid` and `frameErr` are never high together. Each output is at most one pulse per frame.
- There is no backpressure. The consumer must accept the pulse; the next event cannot occur sooner than about 1 frame (≥ 600 µs).
- The data line is not filtered. It is stable for tens of µs around each PS/2 clock fall, which covers the filter delay.

## Structure
- Shared package `ps2_pkg`:
  - FSM state enum (IDLE, DATA, PARITY, STOP).
  - Constants `PS2_PFX_EXT` = 8'hE0 and `PS2_PFX_BRK` = 8'hF0.
- One sub-module, `ps2_line_filter`: 2-FF sync plus the FILTER_LEN glitch filter, outputting the filtered level and the `fall` strobe. It is reusable for a future host-to-device transmitter.
- The FSM, watchdog and prefix folding stay in the top of this block.

## Test plan
- Frame 0x1C (parity 0, stop 1) → one `codeValid` pulse; `scanCode`=0x1C, `isBreak`=0, `isExtended`=0; `frameErr` stays 0.
- Frames F0, 1C → no pulse after F0; a single pulse after 1C with `scanCode`=0x1C, `isBreak`=1. A following frame 1C → `isBreak`=0.
- Frames E0, F0, 75 → single pulse, `scanCode`=0x75, `isExtended`=1, `isBreak`=1.
- Frame 0x1C with parity 1, or with stop bit 0 → `frameErr` pulse, no `codeValid`. A following good 0x32 → `scanCode`=0x32 with both flags 0 (a pending F0 sent before the bad frame is also cleared).
- Start plus 4 data bits, then lines idle 3 ms → `frameErr` pulse after TIMEOUT_CYCLES. A following good 0x29 frame → `scanCode`=0x29.
- Low glitch of FILTER_LEN-3 cycles on `ps2Clk` mid-frame → ignored and the byte is still correct. Asserting `reset` mid-frame → all outputs 0 immediately, and the next full frame decodes normally.
